// File: rtl/vec_feature_serializer_if.sv
// Vector-in / beat-out signal bundle for vec_feature_serializer.
// slave = serializer side, master = vector producer plus beat consumer.
interface vec_feature_serializer_if #(
    parameter int BEAT_W = 32
);
    logic [159:0]      vec_feature;
    logic              vec_feature_v;
    logic [BEAT_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [7:0]        out_beat_idx;

    modport slave (
        input  vec_feature, vec_feature_v, out_ready,
        output out_data, out_valid, out_last, out_beat_idx
    );

    modport master (
        output vec_feature, vec_feature_v, out_ready,
        input  out_data, out_valid, out_last, out_beat_idx
    );
endinterface

// File: rtl/vec_feature_serializer.sv
// Queues 160-bit feature vectors in a FIFO and streams each one as 160/BEAT_W beats, LSB slice first.
// Latency: one cycle from vec_feature_v to out_valid. Backpressure: out_ready stalls beats; vectors arriving into a full FIFO are dropped.
// Optional macro VEC_SER_DROP_CNT_EN enables the saturating dropped-vector counter.
module vec_feature_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int BEAT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    vec_feature_serializer_if.slave   vif,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);
    localparam int              N_BEAT    = 160 / BEAT_W;
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [7:0]      LAST_BEAT = 8'(N_BEAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [159:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic           full_q, empty_q, overflow_q;

    logic           out_vld;
    logic           last_beat;
    logic           handshake;
    logic           pop;
    logic           wr_acc;
    logic [159:0]   head;
    logic [31:0]    shamt;

    assign out_vld   = (state_q == SEND);
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign handshake = out_vld && vif.out_ready;
    assign pop       = handshake && last_beat;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign wr_acc    = vif.vec_feature_v && ((count_q != DEPTH_C) || pop);

    assign head  = mem_q[rptr_q];
    assign shamt = {24'd0, beat_cnt_q} * 32'(BEAT_W);

    assign vif.out_valid    = out_vld;
    assign vif.out_last     = out_vld && last_beat;
    assign vif.out_beat_idx = beat_cnt_q;
    assign vif.out_data     = out_vld ? BEAT_W'(head >> shamt) : '0;

    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign overflow   = overflow_q;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign wptr_d = wr_acc ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = pop    ? rptr_q + 1'b1 : rptr_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (count_d != '0) state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
                    beat_cnt_d = last_beat ? 8'd0 : beat_cnt_q + 8'd1;
                    if (pop && (count_d == '0)) state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            overflow_q <= vif.vec_feature_v && !wr_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_acc) begin
            mem_q[wptr_q] <= vif.vec_feature;
        end
    end

`ifdef VEC_SER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (vif.vec_feature_v && !wr_acc && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vec_feature_serializer.sv
// Randomized and directed bench for vec_feature_serializer against a queue-based reference model.
module tb_vec_feature_serializer;
    localparam int BW    = 32;
    localparam int DEPTH = 4;
    localparam int NB    = 160 / BW;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        fifo_full, fifo_empty, overflow;
    logic [15:0] drop_cnt;

    vec_feature_serializer_if #(.BEAT_W(BW)) vif ();

    vec_feature_serializer #(.FIFO_DEPTH(DEPTH), .BEAT_W(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vif        (vif.slave),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: stored vectors in arrival order, beat position within the head.
    logic [159:0] mq [$];
    int           beat;
    bit           ovf_exp;
    int           drops;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic          exp_vld;
        logic [159:0]  sh;
        logic [BW-1:0] exp_dat;
        logic [15:0]   exp_drop;
        exp_vld = (mq.size() != 0);
        exp_dat = '0;
        if (exp_vld) begin
            sh      = mq[0] >> (beat * BW);
            exp_dat = sh[BW-1:0];
        end
`ifdef VEC_SER_DROP_CNT_EN
        exp_drop = (drops > 65535) ? 16'hFFFF : 16'(drops);
`else
        exp_drop = 16'd0;
`endif
        chk("out_valid", vif.out_valid, exp_vld);
        chk("out_data", vif.out_data, exp_dat);
        chk("out_last", vif.out_last, exp_vld && (beat == NB - 1));
        chk("out_beat_idx", vif.out_beat_idx, exp_vld ? beat : 0);
        chk("fifo_full", fifo_full, mq.size() == DEPTH);
        chk("fifo_empty", fifo_empty, mq.size() == 0);
        chk("overflow", overflow, ovf_exp);
        chk("drop_cnt", drop_cnt, exp_drop);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input bit v, input logic [159:0] vec, input bit rdy);
        vif.vec_feature_v = v;
        vif.vec_feature   = vec;
        vif.out_ready     = rdy;
        if (mq.size() != 0 && rdy) begin
            beat++;
            if (beat == NB) begin
                beat = 0;
                void'(mq.pop_front());
            end
        end
        ovf_exp = 1'b0;
        if (v) begin
            if (mq.size() < DEPTH) mq.push_back(vec);
            else begin
                ovf_exp = 1'b1;
                drops++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        vif.vec_feature_v = 1'b0;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH * NB + 2; i++) step(1'b0, '0, 1'b1);
        chk("drained_empty", fifo_empty, 1'b1);
    endtask

    function automatic logic [159:0] rvec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [159:0] pat;
        logic [31:0]  exp_b [5];
        logic [159:0] tmp;
        logic [159:0] late_vec;

        total = 0;
        bad   = 0;
        beat  = 0;
        drops = 0;
        ovf_exp = 1'b0;
        vif.vec_feature_v = 1'b0;
        vif.vec_feature   = '0;
        vif.out_ready     = 1'b0;

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Single known vector, one beat per cycle.
        pat   = 160'h13121110_0F0E0D0C_0B0A0908_07060504_03020100;
        exp_b = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
        step(1'b1, pat, 1'b1);
        chk("t1_valid_rise", vif.out_valid, 1'b1);
        chk("t1_beat0", vif.out_data, exp_b[0]);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            chk("t1_beat", vif.out_data, exp_b[i]);
            chk("t1_last", vif.out_last, i == 4);
        end
        step(1'b0, '0, 1'b1);
        chk("t1_idle", vif.out_valid, 1'b0);

        // Stall at beat 2 for three cycles.
        step(1'b1, rvec(), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        tmp = {128'd0, vif.out_data};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            chk("bp_idx", vif.out_beat_idx, 8'd2);
            chk("bp_data_hold", vif.out_data, tmp[BW-1:0]);
        end
        drain();

        // Fill with the consumer stalled; the fifth vector is dropped.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rvec(), 1'b0);
            if (i == 3) chk("fill_full", fifo_full, 1'b1);
        end
        chk("fill_overflow", overflow, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("fill_overflow_once", overflow, 1'b0);
        drain();

        // Full FIFO, new vector coincides with the final beat of the head.
        for (int i = 0; i < DEPTH; i++) step(1'b1, rvec(), 1'b0);
        for (int i = 0; i < NB - 1; i++) step(1'b0, '0, 1'b1);
        late_vec = rvec();
        step(1'b1, late_vec, 1'b1);
        chk("cpop_no_overflow", overflow, 1'b0);
        chk("cpop_still_full", fifo_full, 1'b1);
        for (int i = 0; i < 3 * NB; i++) step(1'b0, '0, 1'b1);
        tmp = late_vec;
        chk("cpop_late_head", vif.out_data, tmp[BW-1:0]);
        drain();

        // Asynchronous reset during beat 1 of two queued vectors.
        step(1'b1, rvec(), 1'b0);
        step(1'b1, rvec(), 1'b0);
        step(1'b0, '0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", vif.out_valid, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_idx", vif.out_beat_idx, 8'd0);
        chk("rst_overflow", overflow, 1'b0);
        mq.delete();
        beat    = 0;
        ovf_exp = 1'b0;
        drops   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        tmp = rvec();
        step(1'b1, tmp, 1'b1);
        chk("rst_fresh_idx", vif.out_beat_idx, 8'd0);
        chk("rst_fresh_data", vif.out_data, tmp[BW-1:0]);
        drain();

`ifdef VEC_SER_DROP_CNT_EN
        // Counter saturation under a long run of drops.
        for (int i = 0; i < DEPTH; i++) step(1'b1, rvec(), 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, rvec(), 1'b0);
        chk("sat_drop_cnt", drop_cnt, 16'hFFFF);
        chk("sat_overflow", overflow, 1'b1);
        drain();
`endif

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, rvec(), $urandom_range(0, 3) != 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
